// File: rtl/control_unit_pkg.sv
// Shared RV32I control encodings: opcodes, ALU/immediate/branch/writeback codes
// and the decode bundle carried between the decoder and the datapath ports.
// Used by the control unit, ALU, immediate generator and branch unit.
package control_unit_pkg;

  localparam int unsigned OPC_W    = 7;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned F7_W     = 7;
  localparam int unsigned ALUOP_W  = 4;
  localparam int unsigned IMMSRC_W = 3;
  localparam int unsigned DMCTRL_W = 3;
  localparam int unsigned BROP_W   = 5;
  localparam int unsigned WBSRC_W  = 2;

  typedef logic [ALUOP_W-1:0]  alu_op_t;
  typedef logic [IMMSRC_W-1:0] imm_src_t;
  typedef logic [BROP_W-1:0]   br_op_t;
  typedef logic [WBSRC_W-1:0]  wb_src_t;

  // Major opcodes (instr[6:0])
  localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  // Funct7 values that qualify R-type and shift-immediate encodings
  localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

  // ALU operations; bit 3 is the Funct7[5] "alternate" modifier
  localparam alu_op_t ALU_ADD    = 4'b0000;
  localparam alu_op_t ALU_SUB    = 4'b1000;
  localparam alu_op_t ALU_SLL    = 4'b0001;
  localparam alu_op_t ALU_SLT    = 4'b0010;
  localparam alu_op_t ALU_SLTU   = 4'b0011;
  localparam alu_op_t ALU_XOR    = 4'b0100;
  localparam alu_op_t ALU_SRL    = 4'b0101;
  localparam alu_op_t ALU_SRA    = 4'b1101;
  localparam alu_op_t ALU_OR     = 4'b0110;
  localparam alu_op_t ALU_AND    = 4'b0111;
  localparam alu_op_t ALU_PASS_B = 4'b1111;

  // Immediate formats
  localparam imm_src_t IMM_I = 3'b000;
  localparam imm_src_t IMM_S = 3'b001;
  localparam imm_src_t IMM_B = 3'b101;
  localparam imm_src_t IMM_U = 3'b010;
  localparam imm_src_t IMM_J = 3'b110;

  // Branch-unit control: conditional branches append Funct3 to BR_COND_PFX
  localparam br_op_t           BR_NONE     = 5'b00000;
  localparam logic [1:0]       BR_COND_PFX = 2'b01;
  localparam br_op_t           BR_JUMP     = 5'b10000;

  // Register writeback source
  localparam wb_src_t WB_ALU = 2'b00;
  localparam wb_src_t WB_DM  = 2'b01;
  localparam wb_src_t WB_PC4 = 2'b10;

  // ALU operand source selects
  localparam logic SRC_A_RS1 = 1'b0;
  localparam logic SRC_A_PC  = 1'b1;
  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

  // Complete set of datapath controls produced by the decoder
  typedef struct packed {
    logic                    ru_wr;
    alu_op_t                 alu_op;
    imm_src_t                imm_src;
    logic                    alu_a_src;
    logic                    alu_b_src;
    logic                    dm_wr;
    logic [DMCTRL_W-1:0]     dm_ctrl;
    br_op_t                  br_op;
    wb_src_t                 wb_src;
  } ctrl_t;

  // Load widths: LB, LH, LW, LBU, LHU
  function automatic logic load_f3_ok(input logic [F3_W-1:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // Store widths: SB, SH, SW
  function automatic logic store_f3_ok(input logic [F3_W-1:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
  endfunction

  // Branch conditions: BEQ, BNE, BLT, BGE, BLTU, BGEU (010/011 are reserved)
  function automatic logic branch_f3_ok(input logic [F3_W-1:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

endpackage

// File: rtl/control_unit.sv
// Main decoder of the RV32I single-cycle datapath.
// Ports:
//   clk, rst          - clock and async active-high reset (only for IllegalSeen)
//   OpCode/Funct3/Funct7 - instruction fields instr[6:0], [14:12], [31:25]
//   RUWr, ALUOp, ImmSrc, ALUASrc, ALUBSrc, DMWr, DMCtrl, BrOp, RUDataWrSrc
//                     - combinational datapath controls (zero latency)
//   Illegal           - combinational: current encoding unsupported
//   IllegalSeen       - registered sticky copy of Illegal, cleared only by rst
module control_unit
  import control_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPC_W-1:0]    OpCode,
  input  logic [F3_W-1:0]     Funct3,
  input  logic [F7_W-1:0]     Funct7,
  output logic                RUWr,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [IMMSRC_W-1:0] ImmSrc,
  output logic                ALUASrc,
  output logic                ALUBSrc,
  output logic                DMWr,
  output logic [DMCTRL_W-1:0] DMCtrl,
  output logic [BROP_W-1:0]   BrOp,
  output logic [WBSRC_W-1:0]  RUDataWrSrc,
  output logic                Illegal,
  output logic                IllegalSeen
);

  ctrl_t dec;
  ctrl_t ctrl;
  logic  legal;
  logic  illegal_seen_q;
  logic  illegal_seen_d;

  // Instruction decode; an unsupported encoding zeroes every control so it has no side effect
  always_comb begin
    dec   = '0;
    ctrl  = '0;
    legal = 1'b0;

    case (OpCode)
      OPC_R: begin
        // Only SUB and SRA accept the alternate Funct7
        legal = (Funct7 == F7_BASE) ||
                ((Funct7 == F7_ALT) && ((Funct3 == 3'b000) || (Funct3 == 3'b101)));
        dec.ru_wr     = 1'b1;
        dec.alu_a_src = SRC_A_RS1;
        dec.alu_b_src = SRC_B_RS2;
        dec.alu_op    = {Funct7[5], Funct3};
        dec.wb_src    = WB_ALU;
      end

      OPC_I: begin
        // Shift-immediates carry Funct7 in imm[11:5]; other ops own those bits as immediate
        if (Funct3 == 3'b001) begin
          legal = (Funct7 == F7_BASE);
        end else if (Funct3 == 3'b101) begin
          legal = (Funct7 == F7_BASE) || (Funct7 == F7_ALT);
        end else begin
          legal = 1'b1;
        end
        dec.ru_wr     = 1'b1;
        dec.imm_src   = IMM_I;
        dec.alu_b_src = SRC_B_IMM;
        dec.alu_op    = (Funct3 == 3'b101) ? {Funct7[5], Funct3} : {1'b0, Funct3};
        dec.wb_src    = WB_ALU;
      end

      OPC_LOAD: begin
        legal         = load_f3_ok(Funct3);
        dec.ru_wr     = 1'b1;
        dec.imm_src   = IMM_I;
        dec.alu_b_src = SRC_B_IMM;
        dec.alu_op    = ALU_ADD;
        dec.dm_ctrl   = Funct3;
        dec.wb_src    = WB_DM;
      end

      OPC_STORE: begin
        legal         = store_f3_ok(Funct3);
        dec.dm_wr     = 1'b1;
        dec.imm_src   = IMM_S;
        dec.alu_b_src = SRC_B_IMM;
        dec.alu_op    = ALU_ADD;
        dec.dm_ctrl   = Funct3;
      end

      OPC_BRANCH: begin
        // ALU computes the target PC+imm; the branch unit evaluates the condition
        legal         = branch_f3_ok(Funct3);
        dec.imm_src   = IMM_B;
        dec.alu_a_src = SRC_A_PC;
        dec.alu_b_src = SRC_B_IMM;
        dec.alu_op    = ALU_ADD;
        dec.br_op     = {BR_COND_PFX, Funct3};
      end

      OPC_JAL: begin
        legal         = 1'b1;
        dec.ru_wr     = 1'b1;
        dec.imm_src   = IMM_J;
        dec.alu_a_src = SRC_A_PC;
        dec.alu_b_src = SRC_B_IMM;
        dec.alu_op    = ALU_ADD;
        dec.br_op     = BR_JUMP;
        dec.wb_src    = WB_PC4;
      end

      OPC_JALR: begin
        legal         = (Funct3 == 3'b000);
        dec.ru_wr     = 1'b1;
        dec.imm_src   = IMM_I;
        dec.alu_a_src = SRC_A_RS1;
        dec.alu_b_src = SRC_B_IMM;
        dec.alu_op    = ALU_ADD;
        dec.br_op     = BR_JUMP;
        dec.wb_src    = WB_PC4;
      end

      OPC_LUI: begin
        legal         = 1'b1;
        dec.ru_wr     = 1'b1;
        dec.imm_src   = IMM_U;
        dec.alu_b_src = SRC_B_IMM;
        dec.alu_op    = ALU_PASS_B;
        dec.wb_src    = WB_ALU;
      end

      OPC_AUIPC: begin
        legal         = 1'b1;
        dec.ru_wr     = 1'b1;
        dec.imm_src   = IMM_U;
        dec.alu_a_src = SRC_A_PC;
        dec.alu_b_src = SRC_B_IMM;
        dec.alu_op    = ALU_ADD;
        dec.wb_src    = WB_ALU;
      end

      default: begin
        legal = 1'b0;
      end
    endcase

    ctrl = legal ? dec : ctrl_t'('0);
  end

  assign RUWr        = ctrl.ru_wr;
  assign ALUOp       = ctrl.alu_op;
  assign ImmSrc      = ctrl.imm_src;
  assign ALUASrc     = ctrl.alu_a_src;
  assign ALUBSrc     = ctrl.alu_b_src;
  assign DMWr        = ctrl.dm_wr;
  assign DMCtrl      = ctrl.dm_ctrl;
  assign BrOp        = ctrl.br_op;
  assign RUDataWrSrc = ctrl.wb_src;
  assign Illegal     = ~legal;

  // Sticky flag: once an unsupported encoding is clocked in it holds until reset
  assign illegal_seen_d = illegal_seen_q | ~legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_seen_q <= 1'b0;
    end else begin
      illegal_seen_q <= illegal_seen_d;
    end
  end

  assign IllegalSeen = illegal_seen_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: driver issues instructions (directed then random),
// pushes the reference expectation into a scoreboard queue; a monitor pops and
// compares on the falling edge while the instruction is still applied.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [6:0] OpCode;
  logic [2:0] Funct3;
  logic [6:0] Funct7;
  logic       RUWr;
  logic [3:0] ALUOp;
  logic [2:0] ImmSrc;
  logic       ALUASrc;
  logic       ALUBSrc;
  logic       DMWr;
  logic [2:0] DMCtrl;
  logic [4:0] BrOp;
  logic [1:0] RUDataWrSrc;
  logic       Illegal;
  logic       IllegalSeen;

  control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .OpCode     (OpCode),
    .Funct3     (Funct3),
    .Funct7     (Funct7),
    .RUWr       (RUWr),
    .ALUOp      (ALUOp),
    .ImmSrc     (ImmSrc),
    .ALUASrc    (ALUASrc),
    .ALUBSrc    (ALUBSrc),
    .DMWr       (DMWr),
    .DMCtrl     (DMCtrl),
    .BrOp       (BrOp),
    .RUDataWrSrc(RUDataWrSrc),
    .Illegal    (Illegal),
    .IllegalSeen(IllegalSeen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       ru_wr;
    logic [3:0] alu;
    logic [2:0] imm;
    logic       a_src;
    logic       b_src;
    logic       dm_wr;
    logic [2:0] dm_ctrl;
    logic [4:0] br;
    logic [1:0] wb;
    logic       illegal;
    logic       seen;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic seen_m   = 1'b0;

  // Reference decoder written straight from the instruction table
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    exp_t e;
    logic ok;
    e.name = "";
    e.ru_wr = 0; e.alu = 0; e.imm = 0; e.a_src = 0; e.b_src = 0;
    e.dm_wr = 0; e.dm_ctrl = 0; e.br = 0; e.wb = 0; e.illegal = 0; e.seen = 0;
    ok = 1'b1;
    case (op)
      7'b0110011: begin
        ok = (f7 == 7'd0) || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5));
        e.ru_wr = 1; e.alu = {f7[5], f3};
      end
      7'b0010011: begin
        if (f3 == 3'd1) ok = (f7 == 7'd0);
        else if (f3 == 3'd5) ok = (f7 == 7'd0) || (f7 == 7'b0100000);
        e.ru_wr = 1; e.b_src = 1; e.imm = 3'b000;
        e.alu = (f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3};
      end
      7'b0000011: begin
        ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e.ru_wr = 1; e.b_src = 1; e.dm_ctrl = f3; e.wb = 2'b01;
      end
      7'b0100011: begin
        ok = (f3 <= 3'd2);
        e.dm_wr = 1; e.imm = 3'b001; e.b_src = 1; e.dm_ctrl = f3;
      end
      7'b1100011: begin
        ok = !(f3 inside {3'd2, 3'd3});
        e.imm = 3'b101; e.a_src = 1; e.b_src = 1; e.br = {2'b01, f3};
      end
      7'b1101111: begin
        e.ru_wr = 1; e.imm = 3'b110; e.a_src = 1; e.b_src = 1; e.br = 5'b10000; e.wb = 2'b10;
      end
      7'b1100111: begin
        ok = (f3 == 3'd0);
        e.ru_wr = 1; e.b_src = 1; e.br = 5'b10000; e.wb = 2'b10;
      end
      7'b0110111: begin
        e.ru_wr = 1; e.imm = 3'b010; e.b_src = 1; e.alu = 4'b1111;
      end
      7'b0010111: begin
        e.ru_wr = 1; e.imm = 3'b010; e.a_src = 1; e.b_src = 1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.ru_wr = 0; e.alu = 0; e.imm = 0; e.a_src = 0; e.b_src = 0;
      e.dm_wr = 0; e.dm_ctrl = 0; e.br = 0; e.wb = 0;
    end
    e.illegal = !ok;
    return e;
  endfunction

  // Apply one instruction after the rising edge and record its expectation
  task automatic send(input string nm, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    OpCode = op; Funct3 = f3; Funct7 = f7; rst = r;
    e = model(op, f3, f7);
    e.name = nm;
    e.seen = r ? 1'b0 : seen_m;
    sb_q.push_back(e);
    // Effect of this instruction on the sticky flag at the next rising edge
    seen_m = r ? 1'b0 : (seen_m | e.illegal);
  endtask

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0h expected=%0h (op=%b f3=%b f7=%b)",
               nm, fld, act, exp, OpCode, Funct3, Funct7);
    end
  endtask

  // Monitor: compare whatever instruction is presented, mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.name, "RUWr",        8'(RUWr),        8'(e.ru_wr));
        chk(e.name, "ALUOp",       8'(ALUOp),       8'(e.alu));
        chk(e.name, "ImmSrc",      8'(ImmSrc),      8'(e.imm));
        chk(e.name, "ALUASrc",     8'(ALUASrc),     8'(e.a_src));
        chk(e.name, "ALUBSrc",     8'(ALUBSrc),     8'(e.b_src));
        chk(e.name, "DMWr",        8'(DMWr),        8'(e.dm_wr));
        chk(e.name, "DMCtrl",      8'(DMCtrl),      8'(e.dm_ctrl));
        chk(e.name, "BrOp",        8'(BrOp),        8'(e.br));
        chk(e.name, "RUDataWrSrc", 8'(RUDataWrSrc), 8'(e.wb));
        chk(e.name, "Illegal",     8'(Illegal),     8'(e.illegal));
        chk(e.name, "IllegalSeen", 8'(IllegalSeen), 8'(e.seen));
      end
    end
  end

  logic [6:0] ops [10];

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         sel;
    int         guard;

    rst = 1'b1; OpCode = 7'd0; Funct3 = 3'd0; Funct7 = 7'd0;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};

    // Directed sequence
    send("reset_add", 7'b0110011, 3'b000, 7'b0000000, 1'b1);
    send("add",   7'b0110011, 3'b000, 7'b0000000, 1'b0);
    send("sub",   7'b0110011, 3'b000, 7'b0100000, 1'b0);
    send("lw",    7'b0000011, 3'b010, 7'b0000000, 1'b0);
    send("sw",    7'b0100011, 3'b010, 7'b0000000, 1'b0);
    send("addi",  7'b0010011, 3'b000, 7'b1010101, 1'b0);
    send("srai",  7'b0010011, 3'b101, 7'b0100000, 1'b0);
    send("jalr",  7'b1100111, 3'b000, 7'b0000000, 1'b0);
    send("jal",   7'b1101111, 3'b011, 7'b1111111, 1'b0);
    send("lui",   7'b0110111, 3'b000, 7'b0000000, 1'b0);
    send("auipc", 7'b0010111, 3'b000, 7'b0000000, 1'b0);
    send("bgeu",  7'b1100011, 3'b111, 7'b0000000, 1'b0);
    send("bad_op",   7'b1111111, 3'b000, 7'b0000000, 1'b0);
    send("add_held", 7'b0110011, 3'b000, 7'b0000000, 1'b0);
    send("add_held2",7'b0110011, 3'b000, 7'b0000000, 1'b0);
    send("rst_clear",7'b0110011, 3'b000, 7'b0000000, 1'b1);
    send("add_clr",  7'b0110011, 3'b000, 7'b0000000, 1'b0);
    send("rst_prio", 7'b1111111, 3'b000, 7'b0000000, 1'b1);
    send("after_prio", 7'b0110011, 3'b000, 7'b0000000, 1'b0);
    send("bad_sll7", 7'b0110011, 3'b001, 7'b0100000, 1'b0);
    send("rst2",     7'b0110011, 3'b000, 7'b0000000, 1'b1);
    send("bad_br",   7'b1100011, 3'b010, 7'b0000000, 1'b0);
    send("bad_ld",   7'b0000011, 3'b011, 7'b0000000, 1'b0);
    send("rst3",     7'b0110011, 3'b000, 7'b0000000, 1'b1);
    send("bad_jalr", 7'b1100111, 3'b001, 7'b0000000, 1'b0);

    // Random sequence with occasional resets
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 10);
      op  = (sel == 10) ? 7'($urandom) : ops[sel];
      f3  = 3'($urandom);
      case ($urandom_range(0, 2))
        0:       f7 = 7'b0000000;
        1:       f7 = 7'b0100000;
        default: f7 = 7'($urandom);
      endcase
      send("rand", op, f3, f7, ($urandom_range(0, 39) == 0));
    end

    // Drain the scoreboard with a bounded wait
    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
